pipe_stage_buf: RTL and testbench

- Parametrised successor to the plain IF/ID-style stage register. Generic valid/ready pipeline stage with a 2-entry skid buffer, flush and occupancy reporting.
- Sits between any two pipeline stages (fetch/decode, decode/execute, ...) and replaces the stall/write-enable register scheme.
- Timing property: in_ready is registered (SKID_EN=1), so downstream backpressure never forms a combinational path to upstream.

---
 rtl/pipe_stage_buf_pkg.sv | 5 +
 rtl/pipe_stage_buf_if.sv | 21 ++
 rtl/pipe_stage_buf.sv | 76 +++++++
 tb/tb_pipe_stage_buf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared types for valid/ready pipeline stage buffers.
package pipe_stage_buf_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_t;
  localparam int STAGE_OCC_W = 2;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: upstream/downstream handshake bundle for one pipeline stage.
interface pipe_stage_buf_if import pipe_stage_buf_pkg::*; #(
  parameter int DATA_W = 64
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [STAGE_OCC_W-1:0] occupancy;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with optional 2-entry skid buffer and flush.
module pipe_stage_buf import pipe_stage_buf_pkg::*; #(
  parameter int DATA_W         = 64,
  parameter bit SKID_EN        = 1,
  parameter bit CLEAR_ON_FLUSH = 1
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_buf_if.slave bus
);
  stage_state_t      state;
  logic [DATA_W-1:0] main_q;
  logic              acc;
  logic              take;
  assign acc           = bus.in_valid & bus.in_ready;
  assign take          = bus.out_valid & bus.out_ready;
  assign bus.out_valid = state != ST_EMPTY;
  assign bus.out_data  = main_q;
  // state encoding doubles as the entry count
  assign bus.occupancy = STAGE_OCC_W'(state);
  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      assign bus.in_ready = state != ST_SKID;
      always_ff @(posedge clk) begin
        if (reset) begin
          state  <= ST_EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end else if (bus.flush) begin
          state <= ST_EMPTY;
          if (CLEAR_ON_FLUSH) begin
            main_q <= '0;
            skid_q <= '0;
          end
        end else begin
          case (state)
            ST_EMPTY: if (acc) begin
              state  <= ST_FULL;
              main_q <= bus.in_data;
            end
            ST_FULL: if (acc && take) begin
              main_q <= bus.in_data;
            end else if (acc) begin
              state  <= ST_SKID;
              skid_q <= bus.in_data;
            end else if (take) begin
              state <= ST_EMPTY;
            end
            ST_SKID: if (take) begin
              state  <= ST_FULL;
              main_q <= skid_q;
            end
            default: state <= ST_EMPTY;
          endcase
        end
      end
    end else begin : g_noskid
      assign bus.in_ready = bus.out_ready | ~bus.out_valid;
      always_ff @(posedge clk) begin
        if (reset) begin
          state  <= ST_EMPTY;
          main_q <= '0;
        end else if (bus.flush) begin
          state <= ST_EMPTY;
          if (CLEAR_ON_FLUSH) main_q <= '0;
        end else if (acc) begin
          state  <= ST_FULL;
          main_q <= bus.in_data;
        end else if (take) begin
          state <= ST_EMPTY;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks of three stage variants against a queue model.
module tb_pipe_stage_buf;
  typedef logic [15:0] dq_t[$];
  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [15:0] in_data = '0;
  int          checks = 0;
  int          failures = 0;
  dq_t         q0, q1, q2;
  logic [15:0] ed0 = '0, ed1 = '0, ed2 = '0;
  int          tk0 = 0, tk1 = 0, tk2 = 0;
  bit          armed = 0;
  always #5 clk = ~clk;
  pipe_stage_buf_if #(.DATA_W(16)) b0 ();
  pipe_stage_buf_if #(.DATA_W(16)) b1 ();
  pipe_stage_buf_if #(.DATA_W(16)) b2 ();
  assign b0.flush = flush;
  assign b0.in_valid = in_valid;
  assign b0.in_data = in_data;
  assign b0.out_ready = out_ready;
  assign b1.flush = flush;
  assign b1.in_valid = in_valid;
  assign b1.in_data = in_data;
  assign b1.out_ready = out_ready;
  assign b2.flush = flush;
  assign b2.in_valid = in_valid;
  assign b2.in_data = in_data;
  assign b2.out_ready = out_ready;
  pipe_stage_buf #(.DATA_W(16), .SKID_EN(1), .CLEAR_ON_FLUSH(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  pipe_stage_buf #(.DATA_W(16), .SKID_EN(0), .CLEAR_ON_FLUSH(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  pipe_stage_buf #(.DATA_W(16), .SKID_EN(1), .CLEAR_ON_FLUSH(0)) u2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ed is what out_data must show while the model queue is empty
  task automatic step(input bit skid, input bit clr, inout dq_t q, inout logic [15:0] ed, inout int tk);
    int n = q.size();
    bit ir = skid ? (n < 2) : (out_ready || n == 0);
    bit acc = in_valid && ir;
    bit take = n > 0 && out_ready;
    if (reset) begin
      q.delete();
      ed = '0;
    end else if (flush) begin
      if (take) tk++;
      ed = clr ? 16'h0 : (n > 0 ? q[0] : ed);
      q.delete();
    end else begin
      if (take) begin
        ed = q.pop_front();
        tk++;
      end
      if (acc) q.push_back(in_data);
    end
  endtask

  task automatic mchk(input string tag, input bit skid, input dq_t q, input logic [15:0] ed,
                      input logic ir, input logic ov, input logic [15:0] od, input logic [1:0] occ);
    int n = q.size();
    chk({tag, ".in_ready"}, ir, skid ? (n < 2) : (out_ready || n == 0));
    chk({tag, ".out_valid"}, ov, n > 0);
    chk({tag, ".out_data"}, od, n > 0 ? q[0] : ed);
    chk({tag, ".occupancy"}, occ, n);
  endtask

  always @(posedge clk) begin
    armed = armed | reset;
    step(1, 1, q0, ed0, tk0);
    step(0, 1, q1, ed1, tk1);
    step(1, 0, q2, ed2, tk2);
  end

  always @(negedge clk) if (armed) begin
    mchk("m0", 1, q0, ed0, b0.in_ready, b0.out_valid, b0.out_data, b0.occupancy);
    mchk("m1", 0, q1, ed1, b1.in_ready, b1.out_valid, b1.out_data, b1.occupancy);
    mchk("m2", 1, q2, ed2, b2.in_ready, b2.out_valid, b2.out_data, b2.occupancy);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc = 0;
    int s0, s1;
    tick;
    tick;
    reset = 0;
    #1;
    chk("rst.out_valid", b0.out_valid, 0);
    chk("rst.out_data", b0.out_data, 0);
    chk("rst.occupancy", b0.occupancy, 0);
    chk("rst.in_ready", b0.in_ready, 1);
    chk("rst.in_ready_noskid", b1.in_ready, 1);
    in_valid = 1; out_ready = 1; in_data = 16'hA;
    tick;
    in_data = 16'hB;
    #1;
    chk("stream.a_valid", b0.out_valid, 1);
    chk("stream.a_data", b0.out_data, 16'hA);
    chk("stream.a_occ", b0.occupancy, 1);
    chk("stream.a_noskid", b1.out_data, 16'hA);
    tick;
    in_data = 16'hC;
    #1;
    chk("stream.b_data", b0.out_data, 16'hB);
    chk("stream.b_noskid", b1.out_data, 16'hB);
    tick;
    in_valid = 0;
    #1;
    chk("stream.c_data", b0.out_data, 16'hC);
    tick;
    #1;
    chk("stream.drain_valid", b0.out_valid, 0);
    chk("stream.drain_occ", b0.occupancy, 0);
    out_ready = 0; in_valid = 1; in_data = 16'h1;
    tick;
    in_data = 16'h2;
    #1;
    chk("noskid.stall_ready", b1.in_ready, 0);
    chk("skid.full_ready", b0.in_ready, 1);
    tick;
    #1;
    chk("skid.occ", b0.occupancy, 2);
    chk("skid.in_ready", b0.in_ready, 0);
    chk("skid.main", b0.out_data, 16'h1);
    chk("noskid.occ", b1.occupancy, 1);
    in_valid = 0; out_ready = 1;
    #1;
    chk("noskid.release_ready", b1.in_ready, 1);
    tick;
    #1;
    chk("skid.second", b0.out_data, 16'h2);
    chk("skid.ready_back", b0.in_ready, 1);
    chk("skid.occ1", b0.occupancy, 1);
    chk("noskid.drained", b1.out_valid, 0);
    tick;
    #1;
    chk("skid.drained", b0.out_valid, 0);
    out_ready = 0; in_valid = 1; in_data = 16'h6;
    tick;
    #1;
    chk("noskid.full_ready", b1.in_ready, 0);
    out_ready = 1; in_data = 16'h7;
    #1;
    chk("noskid.pass_ready", b1.in_ready, 1);
    tick;
    in_valid = 0;
    #1;
    chk("noskid.pass_data", b1.out_data, 16'h7);
    chk("noskid.pass_occ", b1.occupancy, 1);
    chk("skid.pass_data", b0.out_data, 16'h7);
    tick;
    out_ready = 0; in_valid = 1; in_data = 16'h1;
    tick;
    in_data = 16'h2;
    tick;
    flush = 1; in_data = 16'h3;
    tick;
    flush = 0; in_valid = 0;
    #1;
    chk("flush.occ", b0.occupancy, 0);
    chk("flush.valid", b0.out_valid, 0);
    chk("flush.clr_data", b0.out_data, 0);
    chk("flush.keep_valid", b2.out_valid, 0);
    chk("flush.keep_data", b2.out_data, 16'h1);
    chk("flush.noskid_data", b1.out_data, 0);
    out_ready = 1;
    tick;
    tick;
    #1;
    chk("flush.no_ghost", b0.out_valid, 0);
    out_ready = 0; in_valid = 1; in_data = 16'h5;
    tick;
    in_valid = 0;
    tick;
    flush = 1;
    tick;
    flush = 0;
    #1;
    chk("keep.valid", b2.out_valid, 0);
    chk("keep.data", b2.out_data, 16'h5);
    chk("keep.clr_data", b0.out_data, 0);
    in_valid = 1; in_data = 16'h8;
    tick;
    in_data = 16'h9;
    tick;
    reset = 1; in_valid = 0;
    tick;
    reset = 0;
    #1;
    chk("midrst.occ", b0.occupancy, 0);
    chk("midrst.valid", b0.out_valid, 0);
    chk("midrst.data", b2.out_data, 0);
    s0 = tk0;
    s1 = tk1;
    while ((tk0 - s0 < 500 || tk1 - s1 < 500) && cyc < 5000) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data = 16'($urandom);
      flush = $urandom_range(0, 49) == 0;
      reset = cyc == 300;
      tick;
      cyc++;
    end
    reset = 0; flush = 0; in_valid = 0;
    chk("rand.budget", cyc < 5000, 1);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
